// File: rtl/dmem_cache.sv
// dmem_cache: direct-mapped, write-back, write-allocate data cache.
// Hits finish in the request cycle. Misses are serviced over a line-wide
// pmem port: an optional victim writeback first, then a fill.
//
// Handshake: dmem_resp high means the presented request (or idle cycle) is
// taken at the next rising edge. While dmem_resp is low the requester holds
// its request unchanged. dmem_ready/dmem_rdata update only on accepting
// edges. On pmem, a request is held stable until a one-cycle pmem_resp.
module dmem_cache #(
  parameter int NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         dmem_read,
  input  logic         dmem_write,
  input  logic [31:0]  dmem_address,
  input  logic [3:0]   dmem_byte_enable,
  input  logic [31:0]  dmem_wdata,
  input  logic         dmem_stall,
  output logic         dmem_resp,
  output logic         dmem_ready,
  output logic [31:0]  dmem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 32 - 5 - IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FILL      = 2'd2
  } state_e;

  state_e              state_q;
  logic [255:0]        data_q [NUM_SETS];
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [IDX_W-1:0]    miss_idx_q;
  logic [TAG_W-1:0]    miss_tag_q;
  logic                ready_q;
  logic [31:0]         rdata_q;

  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [2:0]          req_word;
  logic                req_any;
  logic                req_rd;
  logic                hit;
  logic                idle_go;
  logic [255:0]        cur_line;
  logic [255:0]        merged_line;
  logic [31:0]         rd_word;
  logic                unused_addr_lsb;

  // Byte offset within a word carries no information for word accesses.
  assign unused_addr_lsb = ^dmem_address[1:0];

  assign req_idx  = dmem_address[5+IDX_W-1:5];
  assign req_tag  = dmem_address[31:5+IDX_W];
  assign req_word = dmem_address[4:2];
  assign req_any  = dmem_read | dmem_write;
  assign req_rd   = dmem_read & ~dmem_write;   // write wins when both are set
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign idle_go  = (state_q == ST_IDLE) && !dmem_stall;
  assign cur_line = data_q[req_idx];

  // Accept idle cycles and hits; a miss or a non-idle state stalls the requester.
  assign dmem_resp  = idle_go && (!req_any || hit);
  assign dmem_ready = ready_q;
  assign dmem_rdata = rdata_q;

  // Select the addressed word and build the byte-merged line for a write hit.
  always_comb begin
    rd_word     = '0;
    merged_line = cur_line;
    for (int w = 0; w < 8; w++) begin
      if (req_word == 3'(w)) begin
        rd_word = cur_line[w*32 +: 32];
        for (int b = 0; b < 4; b++) begin
          if (dmem_byte_enable[b]) merged_line[w*32+b*8 +: 8] = dmem_wdata[b*8 +: 8];
        end
      end
    end
  end

  // pmem request decoded from the state and latched miss registers only.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state_q)
      ST_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[miss_idx_q], miss_idx_q, 5'b0};
        pmem_wdata   = data_q[miss_idx_q];
      end
      ST_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {miss_tag_q, miss_idx_q, 5'b0};
      end
      default: ;
    endcase
  end

  // Line data and tags: write-hit merges and fill installs; not reset.
  always_ff @(posedge clk) begin
    if (dmem_resp && dmem_write) begin
      data_q[req_idx] <= merged_line;
    end else if (state_q == ST_FILL && pmem_resp) begin
      data_q[miss_idx_q] <= pmem_rdata;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end
  end

  // Controller FSM plus valid/dirty bits and the read-response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (dmem_resp) begin
        ready_q <= req_rd;
        if (req_rd) rdata_q <= rd_word;
      end
      case (state_q)
        ST_IDLE: begin
          if (idle_go && req_any) begin
            if (hit) begin
              if (dmem_write) dirty_q[req_idx] <= 1'b1;
            end else begin
              miss_idx_q <= req_idx;
              miss_tag_q <= req_tag;
              state_q    <= (valid_q[req_idx] && dirty_q[req_idx]) ? ST_WRITEBACK : ST_FILL;
            end
          end
        end
        ST_WRITEBACK: begin
          if (pmem_resp) begin
            dirty_q[miss_idx_q] <= 1'b0;
            state_q             <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (pmem_resp) begin
            valid_q[miss_idx_q] <= 1'b1;
            dirty_q[miss_idx_q] <= 1'b0;
            state_q             <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_cache.md
# dmem_cache

Data-side cache that sits on the responder end of the CPU datapath's `dmem_*` port. It accepts one read or write request per cycle, returns read data one cycle after acceptance, and backs the port with a direct-mapped, write-back, write-allocate line store. Misses are filled over a 256-bit line-wide physical memory (`pmem_*`) port. While a miss is serviced, `dmem_resp` stays low, which stalls the whole CPU pipeline.

## Interface
- `NUM_SETS`, 8: number of lines (power of 2, ≥2); index = address[5+log2(NUM_SETS)-1:5], tag = remaining upper bits.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `dmem_read` in 1: read request.
- `dmem_write` in 1: write request. If both read and write are high, the request is treated as a write.
- `dmem_address` in 32: word-aligned byte address; bits [1:0] ignored.
- `dmem_byte_enable` in 4: write byte lanes.
- `dmem_wdata` in 32: write data, lane-aligned.
- `dmem_stall` in 1: requester frozen; hold read outputs and accept nothing.
- `dmem_resp` out 1: request (or idle cycle) accepted this cycle; the requester's pipeline advances.
- `dmem_ready` out 1: `dmem_rdata` holds data for the previously accepted read.
- `dmem_rdata` out 32: read word.
- `pmem_read` out 1: line fill request.
- `pmem_write` out 1: line writeback request.
- `pmem_address` out 32: line-aligned address ([4:0]=0).
- `pmem_wdata` out 256: victim line.
- `pmem_rdata` in 256: fill line, valid when `pmem_resp` is high.
- `pmem_resp` in 1: pmem transaction complete (single-cycle pulse).

## Operation
- Storage per set: data[255:0], tag, valid, dirty. Only valid and dirty are reset; data and tag are not.
- Word select is address[4:2]. Word w occupies line bits [32w+31:32w].
- FSM states and transitions:
  - IDLE:
    - No request, or `dmem_stall`=1: `dmem_resp`=1 when stall=0 and 0 when stall=1; no state change.
    - Hit (valid and tag match):
      - `dmem_resp`=1, combinational, in the same cycle.
      - Write: merge enabled bytes into the line and set dirty at the edge.
      - Read: capture the selected word into the `dmem_rdata` register at the edge.
    - Miss: `dmem_resp`=0; go to WRITEBACK if the victim is valid and dirty, else FILL.
  - WRITEBACK: `pmem_write`=1, `pmem_address`={victim tag, index, 5'b0}, `pmem_wdata`=victim line. On `pmem_resp`: clear dirty, go to FILL.
  - FILL: `pmem_read`=1, `pmem_address`={req tag, index, 5'b0}. On `pmem_resp`: write line and tag, set valid=1, dirty=0, go to IDLE.
- After a fill, IDLE re-evaluates the still-held request as a hit. The requester must hold its request while `dmem_resp`=0.
- `dmem_ready`/`dmem_rdata` registers:
  - Update only on edges where `dmem_resp`=1: ready ← accepted read; rdata ← selected word on a read, else held.
  - Held on all other edges.
- `dmem_stall` does not abort a miss in progress; the FSM still completes WRITEBACK/FILL.
- `pmem_read` and `pmem_write` are never both high.
- In IDLE: `pmem_address`=0 and `pmem_wdata`=0.

## Timing
- Reset values: FSM=IDLE, all valid=0, all dirty=0, `dmem_ready`=0, `dmem_rdata`=0, `pmem_read`=0, `pmem_write`=0, `pmem_address`=0, `dmem_resp`=1.
- Reset mid-WRITEBACK/FILL: immediate return to IDLE; the pmem request drops asynchronously; the partial line is discarded.
- Read hit: request in cycle N, `dmem_resp`=1 in N, `dmem_ready`=1 with data in N+1.
- Write hit: completes at the edge ending N. A read to the same address in N+1 returns the merged data (no bypass hazard).
- Clean miss: `dmem_resp`=0 from the request cycle until the cycle after `pmem_resp`, then behaves as a hit. Minimum penalty = pmem latency + 1 cycle.
- Dirty miss: WRITEBACK then FILL, back-to-back. `pmem_read` rises the cycle after the writeback's `pmem_resp`.
- pmem outputs are driven from the FSM state and are stable until `pmem_resp`.

## Test plan
- Cold read: reset; read 0x100. Response: `dmem_resp`=0 and `pmem_read`=1 with address 0x100. pmem replies after 3 cycles with word0=0xDEADBEEF. The next cycle has `dmem_resp`=1, and the cycle after has `dmem_ready`=1 and `dmem_rdata`=0xDEADBEEF.
- Byte write hit: after the fill of 0x100 with word1=0x11223344, write 0x104 with be=4'h2 and wdata=0x0000AB00, then read 0x104 → `dmem_rdata`=0x1122AB44. Both accesses are accepted with no stall.
- Dirty eviction (`NUM_SETS`=8): dirty line 0x100, then read 0x200 (same index 0).
  - `pmem_write` with address 0x100 and the merged line.
  - Then `pmem_read` with address 0x200.
  - Line 0x200 is installed clean, and the read returns its word0.
- Stall hold: read hit returns 0x5; the next cycle raises `dmem_stall` while reading 0x108. `dmem_resp`=0, and ready/rdata hold at 1/0x5 until stall drops.
- Idle cycles: an accepted read followed by a cycle with no request → `dmem_ready` falls to 0 and rdata holds. `dmem_resp` stays 1.
- Async reset during FILL: assert `rst_n`=0 mid-FILL → `pmem_read`=0 immediately. A subsequent read of the same address misses again (valid cleared).
